// File: rtl/l1_read_arbiter_pkg.sv
// l1_read_arbiter_pkg: shared types and helpers for the L1 burst-read arbiter
package l1_read_arbiter_pkg;
  localparam int L1_READ_ADDR_W = 30;
  localparam int L1_READ_RLEN_W = 5;
  localparam int L1_READ_ID_W = 4;
  typedef enum logic {IDLE, GRANTED} l1_read_state_t;
  typedef struct packed {
    logic [L1_READ_ID_W-1:0] id;
    logic [L1_READ_RLEN_W-1:0] rlen;
  } l1_read_track_t;
  function automatic logic [L1_READ_ID_W-1:0] rr_next(input logic [L1_READ_ID_W-1:0] id, input int n);
    return (int'(id) + 1 >= n) ? '0 : L1_READ_ID_W'(int'(id) + 1);
  endfunction
endpackage

// File: rtl/l1_read_arbiter_fifo.sv
// l1_read_arbiter_fifo: small synchronous FIFO tracking in-flight bursts
module l1_read_arbiter_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              full_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p);
    return (int'(p) == DEPTH - 1) ? '0 : PW'(int'(p) + 1);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wrap(wr_q);
      if (pop_i) rd_q <= wrap(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= data_i;
  end
  assign data_o = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign full_o = cnt_q == CW'(DEPTH);
  assert property (@(posedge clk) disable iff (rst) push_i |-> !full_o || pop_i);
  assert property (@(posedge clk) disable iff (rst) pop_i |-> valid_o);
endmodule

// File: rtl/l1_read_arbiter.sv
// l1_read_arbiter: round-robin sharing of one in-order burst-read port
// between several read-only requesters, with returned words routed to their owner.
module l1_read_arbiter
  import l1_read_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   req_request_i,
  input  logic [NUM_PORTS*30-1:0] req_addr_i,
  input  logic [NUM_PORTS*5-1:0] req_rlen_i,
  output logic [NUM_PORTS-1:0]   req_ack_o,
  output logic [NUM_PORTS-1:0]   req_rvalid_o,
  output logic [31:0]            req_rdata_o,
  output logic                   mem_request_o,
  output logic [29:0]            mem_addr_o,
  output logic [4:0]             mem_rlen_o,
  input  logic                   mem_ack_i,
  input  logic                   mem_rvalid_i,
  input  logic [31:0]            mem_rdata_i
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  l1_read_state_t state_q;
  logic [L1_READ_ID_W-1:0] grant_id_q, rr_ptr_q, win_id;
  logic [L1_READ_ADDR_W-1:0] grant_addr_q;
  logic [L1_READ_RLEN_W-1:0] grant_rlen_q, word_cnt_q;
  logic win_valid, ack, fifo_full, fifo_valid, beat, pop;
  l1_read_track_t head, push_entry;
  // Descending scan so the lowest offset from the pointer wins last.
  always_comb begin
    win_id = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_request_i[IW'((int'(rr_ptr_q) + i) % NUM_PORTS)]) win_id = L1_READ_ID_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
    end
  end
  assign win_valid = |req_request_i;
  assign ack = state_q == GRANTED && mem_ack_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      grant_id_q <= '0;
      grant_addr_q <= '0;
      grant_rlen_q <= '0;
    end else if (ack) begin
      state_q <= IDLE;
      rr_ptr_q <= rr_next(grant_id_q, NUM_PORTS);
    end else if (state_q == IDLE && win_valid && !fifo_full) begin
      state_q <= GRANTED;
      grant_id_q <= win_id;
      grant_addr_q <= req_addr_i[int'(win_id)*30 +: 30];
      grant_rlen_q <= req_rlen_i[int'(win_id)*5 +: 5];
    end
  end
  assign mem_request_o = state_q == GRANTED;
  assign mem_addr_o = grant_addr_q;
  assign mem_rlen_o = grant_rlen_q;
  assign req_ack_o = ack ? NUM_PORTS'(1) << grant_id_q : '0;
  assign push_entry = '{id: grant_id_q, rlen: grant_rlen_q};
  // A grant is only taken with a free slot, so the push at ack never overflows.
  l1_read_arbiter_fifo #(
    .DATA_W($bits(l1_read_track_t)),
    .DEPTH(MAX_OUTSTANDING)
  ) track_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(ack),
    .pop_i(pop),
    .data_i(push_entry),
    .data_o(head),
    .valid_o(fifo_valid),
    .full_o(fifo_full)
  );
  assign beat = mem_rvalid_i && fifo_valid;
  assign pop = beat && word_cnt_q == head.rlen;
  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else if (beat) word_cnt_q <= pop ? '0 : word_cnt_q + 5'd1;
  end
  assign req_rdata_o = mem_rdata_i;
  assign req_rvalid_o = beat ? NUM_PORTS'(1) << head.id : '0;
  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack_o));
  assert property (@(posedge clk) disable iff (rst) (req_request_i & $past(req_ack_o)) == '0);
  assert property (@(posedge clk) disable iff (rst) mem_ack_i |-> mem_request_o);
  assert property (@(posedge clk) disable iff (rst) mem_rvalid_i |-> fifo_valid);
endmodule

// File: tb/tb_l1_read_arbiter.sv
// tb_l1_read_arbiter: randomized scoreboard bench with a behavioural arbiter/memory model
module tb_l1_read_arbiter;
  localparam int NP = 3;
  localparam int MO = 2;
  logic clk = 0;
  logic rst;
  logic [NP-1:0] req_request;
  logic [NP*30-1:0] req_addr;
  logic [NP*5-1:0] req_rlen;
  logic [NP-1:0] req_ack_o, req_rvalid_o;
  logic [31:0] req_rdata_o;
  logic mem_request_o;
  logic [29:0] mem_addr_o;
  logic [4:0] mem_rlen_o;
  logic mem_ack, mem_rvalid;
  logic [31:0] mem_rdata;
  l1_read_arbiter #(.NUM_PORTS(NP), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .req_request_i(req_request), .req_addr_i(req_addr), .req_rlen_i(req_rlen),
    .req_ack_o(req_ack_o), .req_rvalid_o(req_rvalid_o), .req_rdata_o(req_rdata_o),
    .mem_request_o(mem_request_o), .mem_addr_o(mem_addr_o), .mem_rlen_o(mem_rlen_o),
    .mem_ack_i(mem_ack), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [NP-1:0] port; logic [31:0] data;} exp_t;
  int checks = 0, errors = 0;
  bit pend [NP];
  bit drop_next [NP];
  logic [29:0] p_addr [NP];
  logic [4:0] p_rlen [NP];
  int req_prob [NP];
  int ack_delay, rv_prob, rv_budget, gnt_age;
  bit force_ack, hold_rv;
  logic [31:0] mem_q [$];
  bit m_gnt;
  int m_id, m_ptr;
  logic [29:0] m_addr;
  logic [4:0] m_rlen;
  int m_rem [$];
  exp_t exp_q [$];
  exp_t e;
  int ack_log [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [29:0] a, input int k);
    return (({2'b00, a} + 32'(k)) * 32'h9E37_79B1) ^ 32'h0F0F_5A5A;
  endfunction

  task automatic raise(input int p, input logic [29:0] a, input logic [4:0] l);
    pend[p] = 1;
    p_addr[p] = a;
    p_rlen[p] = l;
  endtask

  function automatic bit busy();
    bit b = m_gnt || m_rem.size() > 0 || mem_q.size() > 0 || exp_q.size() > 0;
    for (int p = 0; p < NP; p++) b |= pend[p];
    return b;
  endfunction

  // One clock: drive requesters and memory at negedge, then check and advance the model.
  task automatic cycle();
    int occ;
    logic [NP-1:0] exp_ack;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      bit dn = drop_next[p];
      drop_next[p] = 0;
      if (!dn && !pend[p] && $urandom_range(0, 99) < req_prob[p]) raise(p, 30'($urandom), 5'($urandom_range(0, 7)));
      req_request[p] = pend[p] && !dn;
      req_addr[p*30 +: 30] = p_addr[p];
      req_rlen[p*5 +: 5] = p_rlen[p];
    end
    mem_ack = mem_request_o && (force_ack || (ack_delay < 0 ? $urandom_range(0, 1) == 1 : gnt_age >= ack_delay));
    gnt_age = (mem_request_o && !mem_ack) ? gnt_age + 1 : 0;
    if (!hold_rv && mem_q.size() > 0 && rv_budget != 0 && $urandom_range(0, 99) < rv_prob) begin
      mem_rvalid = 1;
      mem_rdata = mem_q.pop_front();
      if (rv_budget > 0) rv_budget--;
    end else begin
      mem_rvalid = 0;
      mem_rdata = $urandom;
    end
    #1;
    occ = m_rem.size();
    exp_ack = '0;
    chk("mem_request", 64'(mem_request_o), 64'(m_gnt));
    if (m_gnt) begin
      chk("mem_addr", 64'(mem_addr_o), 64'(m_addr));
      chk("mem_rlen", 64'(mem_rlen_o), 64'(m_rlen));
      if (mem_ack) exp_ack = NP'(1) << m_id;
    end
    chk("req_ack", 64'(req_ack_o), 64'(exp_ack));
    for (int p = 0; p < NP; p++) if (req_ack_o[p]) ack_log.push_back(p);
    if (mem_rvalid && occ > 0) begin
      m_rem[0] = m_rem[0] - 1;
      if (m_rem[0] == 0) void'(m_rem.pop_front());
    end
    if (m_gnt && mem_ack) begin
      m_rem.push_back(int'(m_rlen) + 1);
      for (int k = 0; k <= int'(m_rlen); k++) begin
        e.port = NP'(1) << m_id;
        e.data = mdata(m_addr, k);
        exp_q.push_back(e);
      end
      for (int k = 0; k <= int'(mem_rlen_o); k++) mem_q.push_back(mdata(mem_addr_o, k));
      m_ptr = (m_id + 1) % NP;
      m_gnt = 0;
      pend[m_id] = 0;
      drop_next[m_id] = 1;
      force_ack = 0;
    end else if (!m_gnt && req_request != '0 && occ < MO) begin
      for (int i = 0; i < NP; i++) begin
        int c = (m_ptr + i) % NP;
        if ((req_request & (NP'(1) << c)) != '0) begin
          m_id = c;
          break;
        end
      end
      m_gnt = 1;
      m_addr = p_addr[m_id];
      m_rlen = p_rlen[m_id];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    req_request = '0;
    mem_ack = 0;
    mem_rvalid = 0;
    for (int p = 0; p < NP; p++) begin
      pend[p] = 0;
      drop_next[p] = 0;
      req_prob[p] = 0;
    end
    mem_q.delete();
    m_rem.delete();
    exp_q.delete();
    ack_log.delete();
    m_gnt = 0;
    m_ptr = 0;
    gnt_age = 0;
    force_ack = 0;
    hold_rv = 0;
    rv_prob = 100;
    rv_budget = -1;
    ack_delay = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mem_request", 64'(mem_request_o), 64'(0));
    chk("rst_req_ack", 64'(req_ack_o), 64'(0));
    chk("rst_req_rvalid", 64'(req_rvalid_o), 64'(0));
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    for (int p = 0; p < NP; p++) req_prob[p] = 0;
    hold_rv = 0;
    rv_budget = -1;
    if (ack_delay > 8) ack_delay = 0;
    while (busy() && n < maxc) begin
      cycle();
      n++;
    end
    checks++;
    if (busy()) begin
      errors++;
      $display("FAIL drain_timeout: got pending exp=%0d bursts=%0d expected idle", exp_q.size(), m_rem.size());
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Scoreboard monitor: every presented word must match the oldest expected word.
  initial begin
    exp_t got;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && req_rvalid_o != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rvalid_unexpected: got %0h expected none", req_rvalid_o);
        end else begin
          got = exp_q.pop_front();
          chk("rvalid_port", 64'(req_rvalid_o), 64'(got.port));
          chk("rdata", 64'(req_rdata_o), 64'(got.data));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1;
    req_request = '0;
    req_addr = '0;
    req_rlen = '0;
    mem_ack = 0;
    mem_rvalid = 0;
    mem_rdata = '0;
    // single 8-word burst, memory acks after 2 cycles
    do_reset();
    ack_delay = 2;
    raise(0, 30'h100, 5'd7);
    drain(100);
    chk("t1_acks", 64'(ack_log.size()), 64'(1));
    // simultaneous requests, pointer 0
    do_reset();
    raise(0, 30'h200, 5'd3);
    raise(1, 30'h300, 5'd3);
    drain(100);
    chk("t2_ack_count", 64'(ack_log.size()), 64'(2));
    if (ack_log.size() == 2) begin
      chk("t2_first", 64'(ack_log[0]), 64'(0));
      chk("t2_second", 64'(ack_log[1]), 64'(1));
    end
    // tracking FIFO full: third port stalls until the first burst completes
    do_reset();
    hold_rv = 1;
    raise(0, 30'h1000, 5'd1);
    raise(1, 30'h2000, 5'd1);
    raise(2, 30'h3000, 5'd1);
    run(12);
    chk("t3_acks", 64'(ack_log.size()), 64'(2));
    chk("t3_stall", 64'(mem_request_o), 64'(0));
    drain(100);
    chk("t3_total_acks", 64'(ack_log.size()), 64'(3));
    // new ack coincides with the final word of the previous 1-word burst
    do_reset();
    hold_rv = 1;
    ack_delay = 1000;
    raise(0, 30'h400, 5'd0);
    raise(1, 30'h500, 5'd0);
    n = 0;
    while (!(m_gnt && m_id == 0) && n < 20) begin cycle(); n++; end
    force_ack = 1;
    cycle();
    n = 0;
    while (!(m_gnt && m_id == 1) && n < 20) begin cycle(); n++; end
    force_ack = 1;
    hold_rv = 0;
    cycle();
    chk("t4_ack1", 64'(req_ack_o), 64'(3'b010));
    chk("t4_pop0", 64'(req_rvalid_o), 64'(3'b001));
    cycle();
    chk("t4_route1", 64'(req_rvalid_o), 64'(3'b010));
    drain(100);
    // reset after 3 of 8 words
    do_reset();
    rv_budget = 3;
    raise(0, 30'h600, 5'd7);
    n = 0;
    while (rv_budget != 0 && n < 40) begin cycle(); n++; end
    chk("t5_words", 64'(rv_budget), 64'(0));
    do_reset();
    raise(1, 30'h700, 5'd2);
    cycle();
    cycle();
    chk("t5_regrant", 64'(mem_addr_o), 64'(30'h700));
    drain(100);
    // fairness: ports 0 and 1 continuously requesting
    do_reset();
    req_prob[0] = 100;
    req_prob[1] = 100;
    run(60);
    chk("t6_ack_volume", 64'(ack_log.size() >= 10), 64'(1));
    for (int i = 1; i < ack_log.size(); i++) chk("t6_alternate", 64'(ack_log[i]), 64'(1 - ack_log[i-1]));
    drain(200);
    // randomized traffic
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      for (int p = 0; p < NP; p++) req_prob[p] = $urandom_range(0, 60);
      ack_delay = int'($urandom_range(0, 4)) - 1;
      rv_prob = $urandom_range(30, 100);
      run(200);
    end
    drain(1000);
    chk("end_scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
